// File: rtl/wind_pkg.sv
// Shared types and pattern helpers for the wind-direction light driver.
// Optional build macro WIND_TRAIL_EN is consumed in wind_pattern_gen.
package wind_pkg;

    typedef enum logic [1:0] {
        CALM = 2'b00,
        RTL  = 2'b01,
        LTR  = 2'b10,
        HOLD = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        CALM_OUT = 2'b00,
        CALM_IN  = 2'b01,
        SWEEP    = 2'b10
    } state_t;

    // Widest lamp bank the helpers can describe; callers truncate to N.
    localparam int unsigned MAX_LIGHTS = 64;

    // Middle lamp for odd n, middle pair for even n.
    function automatic logic [MAX_LIGHTS-1:0] center_pat(input int unsigned n);
        logic [MAX_LIGHTS-1:0] p;
        p = '0;
        if ((n % 2) == 0) begin
            p = (MAX_LIGHTS'(1) << (n / 2)) | (MAX_LIGHTS'(1) << (n / 2 - 1));
        end else begin
            p = MAX_LIGHTS'(1) << ((n - 1) / 2);
        end
        return p;
    endfunction

    // Both end lamps.
    function automatic logic [MAX_LIGHTS-1:0] outer_pat(input int unsigned n);
        return MAX_LIGHTS'(1) | (MAX_LIGHTS'(1) << (n - 1));
    endfunction

endpackage

// File: rtl/wind_pattern_gen_if.sv
// Control/lamp bundle between input decode and the pattern generator.
interface wind_pattern_gen_if
    import wind_pkg::*;
#(
    parameter int unsigned N_LIGHTS = 8,
    parameter int unsigned RATE_W   = 4
);
    dir_t                dir;
    logic                enable;
    logic [RATE_W-1:0]   rate;
    logic [N_LIGHTS-1:0] pattern;
    logic                tick;

    modport master (output dir, output enable, output rate,
                    input  pattern, input tick);
    modport slave  (input  dir, input  enable, input  rate,
                    output pattern, output tick);
endinterface

// File: rtl/wind_prescaler.sv
// Programmable advance prescaler: advance fires every rate+1 enabled cycles.
module wind_prescaler #(
    parameter int unsigned RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate,
    output logic              advance
);
    logic [RATE_W-1:0] cnt_q;

    // >= rather than == so lowering rate below the count advances promptly.
    assign advance = enable && (cnt_q >= rate);

    // Count enabled cycles, clear on advance, freeze while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/wind_pattern_gen.sv
// Runway wind-direction lamp driver: calm flash or single-lamp sweep.
// Build macro WIND_TRAIL_EN lights the lamp behind the sweep head.
module wind_pattern_gen
    import wind_pkg::*;
#(
    parameter int unsigned N_LIGHTS = 8,
    parameter int unsigned RATE_W   = 4
) (
    input logic               clk,
    input logic               reset,
    wind_pattern_gen_if.slave bus
);
    localparam int unsigned POS_W = $clog2(N_LIGHTS);
    localparam logic [POS_W-1:0]    POS_MAX = POS_W'(N_LIGHTS - 1);
    localparam logic [N_LIGHTS-1:0] CENTER  = N_LIGHTS'(center_pat(N_LIGHTS));
    localparam logic [N_LIGHTS-1:0] OUTER   = N_LIGHTS'(outer_pat(N_LIGHTS));

    logic                advance;
    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                ltr_q, ltr_d;
    logic [N_LIGHTS-1:0] pattern_q, pattern_d;
    logic                tick_q;
    logic [N_LIGHTS-1:0] sweep_pat;
    logic                state_legal;

    wind_prescaler #(.RATE_W(RATE_W)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (bus.enable),
        .rate    (bus.rate),
        .advance (advance)
    );

    // Next state, position and travel direction; only moves on advance.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        ltr_d       = ltr_q;
        state_legal = (state_q == CALM_OUT) || (state_q == CALM_IN) || (state_q == SWEEP);
        if (advance) begin
            if (!state_legal) begin
                state_d = CALM_IN;
            end else begin
                case (bus.dir)
                    CALM: state_d = (state_q == CALM_IN) ? CALM_OUT : CALM_IN;
                    RTL: begin
                        state_d = SWEEP;
                        ltr_d   = 1'b0;
                        if (state_q == SWEEP)
                            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                        else
                            pos_d = '0;
                    end
                    LTR: begin
                        state_d = SWEEP;
                        ltr_d   = 1'b1;
                        if (state_q == SWEEP)
                            pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                        else
                            pos_d = POS_MAX;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lamp decode from the next state so the pattern register tracks it.
    always_comb begin
        sweep_pat = N_LIGHTS'(1) << pos_d;
`ifdef WIND_TRAIL_EN
        if (ltr_d)
            sweep_pat = sweep_pat | (N_LIGHTS'(1) << ((pos_d == POS_MAX) ? '0 : pos_d + 1'b1));
        else
            sweep_pat = sweep_pat | (N_LIGHTS'(1) << ((pos_d == '0) ? POS_MAX : pos_d - 1'b1));
`else
        sweep_pat = sweep_pat;
`endif
        case (state_d)
            SWEEP:    pattern_d = sweep_pat;
            CALM_OUT: pattern_d = OUTER;
            default:  pattern_d = CENTER;
        endcase
    end

    // State, pattern and tick registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CALM_IN;
            pos_q     <= '0;
            ltr_q     <= 1'b0;
            pattern_q <= CENTER;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            ltr_q     <= ltr_d;
            pattern_q <= pattern_d;
            tick_q    <= advance;
        end
    end

    assign bus.pattern = pattern_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_wind_pattern_gen.sv
// Directed bench for wind_pattern_gen (N_LIGHTS=8, RATE_W=4).
module tb_wind_pattern_gen;
    import wind_pkg::*;

`ifdef WIND_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    wind_pattern_gen_if #(.N_LIGHTS(8), .RATE_W(4)) bus ();

    wind_pattern_gen #(.N_LIGHTS(8), .RATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sweep(input int pos, input bit ltr);
        logic [7:0] p;
        p = 8'd1 << pos;
        if (TRAIL) p = p | (8'd1 << (ltr ? (pos + 1) % 8 : (pos + 7) % 8));
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_pat, input logic exp_tick);
        checks++;
        assert (bus.pattern === exp_pat) else begin
            errors++;
            $error("FAIL %s pattern: got %b expected %b", tag, bus.pattern, exp_pat);
        end
        checks++;
        assert (bus.tick === exp_tick) else begin
            errors++;
            $error("FAIL %s tick: got %b expected %b", tag, bus.tick, exp_tick);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.dir = RTL;
        bus.enable = 1'b1;
        bus.rate = 4'd0;

        cyc(); chk("reset1", 8'b00011000, 1'b0);
        cyc(); chk("reset2", 8'b00011000, 1'b0);
        reset = 1'b0;
        bus.dir = CALM;
        chk("release", 8'b00011000, 1'b0);

        cyc(); chk("calm_out1", 8'b10000001, 1'b1);
        cyc(); chk("calm_in1",  8'b00011000, 1'b1);
        cyc(); chk("calm_out2", 8'b10000001, 1'b1);
        cyc(); chk("calm_in2",  8'b00011000, 1'b1);

        bus.dir = RTL;
        for (int i = 0; i < 8; i++) begin
            cyc(); chk($sformatf("rtl_%0d", i), sweep(i, 1'b0), 1'b1);
        end
        cyc(); chk("rtl_wrap", sweep(0, 1'b0), 1'b1);
        for (int i = 1; i < 5; i++) begin
            cyc(); chk($sformatf("rtl_b%0d", i), sweep(i, 1'b0), 1'b1);
        end
        bus.dir = LTR;
        cyc(); chk("reverse_ltr", sweep(3, 1'b1), 1'b1);
        cyc(); chk("ltr_2",       sweep(2, 1'b1), 1'b1);
        bus.dir = RTL;
        cyc(); chk("rtl_c3", sweep(3, 1'b0), 1'b1);
        cyc(); chk("rtl_c4", sweep(4, 1'b0), 1'b1);
        cyc(); chk("rtl_c5", sweep(5, 1'b0), 1'b1);

        bus.dir = HOLD;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk($sformatf("hold_%0d", i), sweep(5, 1'b0), 1'b1);
        end
        bus.dir = RTL;
        cyc(); chk("after_hold", sweep(6, 1'b0), 1'b1);
        cyc(); chk("rtl_d7", sweep(7, 1'b0), 1'b1);
        cyc(); chk("rtl_d0", sweep(0, 1'b0), 1'b1);
        cyc(); chk("rtl_d1", sweep(1, 1'b0), 1'b1);
        cyc(); chk("rtl_d2", sweep(2, 1'b0), 1'b1);

        reset = 1'b1;
        cyc(); chk("reset_mid", 8'b00011000, 1'b0);
        reset = 1'b0;
        bus.dir = CALM;
        bus.rate = 4'd3;

        for (int i = 1; i <= 3; i++) begin
            cyc(); chk($sformatf("r3_wait_a%0d", i), 8'b00011000, 1'b0);
        end
        cyc(); chk("r3_adv_a", 8'b10000001, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            cyc(); chk($sformatf("r3_wait_b%0d", i), 8'b10000001, 1'b0);
        end
        cyc(); chk("r3_adv_b", 8'b00011000, 1'b1);
        cyc(); chk("r3_cnt1", 8'b00011000, 1'b0);
        cyc(); chk("r3_cnt2", 8'b00011000, 1'b0);

        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk($sformatf("frozen_%0d", i), 8'b00011000, 1'b0);
        end
        bus.enable = 1'b1;
        cyc(); chk("resume_cnt3", 8'b00011000, 1'b0);
        cyc(); chk("resume_adv",  8'b10000001, 1'b1);

        bus.rate = 4'd7;
        for (int i = 1; i <= 5; i++) begin
            cyc(); chk($sformatf("r7_cnt%0d", i), 8'b10000001, 1'b0);
        end
        bus.rate = 4'd1;
        cyc(); chk("rate_lowered", 8'b00011000, 1'b1);
        cyc(); chk("r1_wait",      8'b00011000, 1'b0);
        cyc(); chk("r1_adv",       8'b10000001, 1'b1);

        bus.rate = 4'd0;
        bus.dir = LTR;
        cyc(); chk("ltr_from_calm", sweep(7, 1'b1), 1'b1);
        cyc(); chk("ltr_step",      sweep(6, 1'b1), 1'b1);
        bus.dir = CALM;
        cyc(); chk("sweep_to_calm", 8'b00011000, 1'b1);
        bus.enable = 1'b0;
        cyc(); chk("disabled_r0", 8'b00011000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
